bus_host_arbiter: RTL

BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

---
 rtl/bus_host_arbiter_if.sv | 47 ++++
 rtl/bus_host_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter_if.sv
// Bundle of per-host request/response lanes and the single downstream bus host port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface bus_host_arbiter_if #(
   parameter int NrHosts      = 2,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   localparam int BeWidth = DataWidth / 8;

   logic [NrHosts-1:0]                   host_req_i;
   logic [NrHosts-1:0]                   host_we_i;
   logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
   logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
   logic [NrHosts-1:0][BeWidth-1:0]      host_be_i;
   logic [NrHosts-1:0]                   host_gnt_o;
   logic [NrHosts-1:0]                   host_rvalid_o;
   logic [NrHosts-1:0]                   host_err_o;
   logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;

   logic                    dev_req_o;
   logic                    dev_we_o;
   logic [AddressWidth-1:0] dev_addr_o;
   logic [BeWidth-1:0]      dev_be_o;
   logic [DataWidth-1:0]    dev_wdata_o;
   logic                    dev_gnt_i;
   logic                    dev_rvalid_i;
   logic                    dev_err_i;
   logic [DataWidth-1:0]    dev_rdata_i;

   logic                    protocol_err_o;

   modport slave (
      input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_be_i,
      output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
      output dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o,
      input  dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i,
      output protocol_err_o
   );

   modport master (
      output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_be_i,
      input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
      input  dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o,
      output dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i,
      input  protocol_err_o
   );
endinterface

// File: rtl/bus_host_arbiter.sv
// N-host to one-bus arbiter with an owner FIFO that routes in-order responses back.
// Define BUS_HOST_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module bus_host_arbiter #(
   parameter int NrHosts        = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2
) (
   input logic               clk_i,
   input logic               rst_ni,
   bus_host_arbiter_if.slave bus
);
   localparam int IdxW    = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW    = $clog2(MaxOutstanding + 1);
   localparam int BeWidth = DataWidth / 8;

   logic              winnerValid;
   logic [IdxW-1:0]   winnerIdx;
   logic              devReq;
   logic              handshake;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              pop;
   logic [IdxW-1:0]   head;

   logic [IdxW-1:0]   owners_q [MaxOutstanding];
   logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              protoErr_q, protoErr_d;

   function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

`ifdef BUS_HOST_ARB_FIXED_PRIO_EN
   always_comb begin
      winnerValid = 1'b0;
      winnerIdx   = '0;
      for (int i = 0; i < NrHosts; i++) begin
         if (!winnerValid && bus.host_req_i[i]) begin
            winnerValid = 1'b1;
            winnerIdx   = IdxW'(i);
         end
      end
   end
`else
   logic [IdxW-1:0] prioPtr_q, prioPtr_d;
   logic [IdxW-1:0] candidate;

   // Search upward from the priority pointer, wrapping at NrHosts.
   always_comb begin
      winnerValid = 1'b0;
      winnerIdx   = '0;
      candidate   = '0;
      for (int i = 0; i < NrHosts; i++) begin
         candidate = IdxW'((int'(prioPtr_q) + i) % NrHosts);
         if (!winnerValid && bus.host_req_i[candidate]) begin
            winnerValid = 1'b1;
            winnerIdx   = candidate;
         end
      end
   end

   always_comb begin
      prioPtr_d = prioPtr_q;
      if (handshake) begin
         prioPtr_d = (winnerIdx == IdxW'(NrHosts - 1)) ? '0 : winnerIdx + IdxW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prioPtr_q <= '0;
      end else begin
         prioPtr_q <= prioPtr_d;
      end
   end
`endif

   // Fullness uses registered occupancy so a same-cycle pop never re-opens the bus.
   assign fifoFull  = (count_q == CntW'(MaxOutstanding));
   assign fifoEmpty = (count_q == '0);
   assign devReq    = winnerValid & ~fifoFull;
   assign handshake = devReq & bus.dev_gnt_i;
   assign pop       = bus.dev_rvalid_i & ~fifoEmpty;
   assign head      = owners_q[rdPtr_q];

   assign bus.dev_req_o      = devReq;
   assign bus.protocol_err_o = protoErr_q;

   always_comb begin
      bus.dev_we_o    = 1'b0;
      bus.dev_addr_o  = '0;
      bus.dev_be_o    = '0;
      bus.dev_wdata_o = '0;
      if (devReq) begin
         bus.dev_we_o    = bus.host_we_i[winnerIdx];
         bus.dev_addr_o  = bus.host_addr_i[winnerIdx];
         bus.dev_be_o    = bus.host_be_i[winnerIdx];
         bus.dev_wdata_o = bus.host_wdata_i[winnerIdx];
      end
   end

   always_comb begin
      bus.host_gnt_o    = '0;
      bus.host_rvalid_o = '0;
      bus.host_err_o    = '0;
      bus.host_rdata_o  = '0;
      if (handshake) begin
         bus.host_gnt_o[winnerIdx] = 1'b1;
      end
      if (pop) begin
         bus.host_rvalid_o[head] = 1'b1;
         bus.host_err_o[head]    = bus.dev_err_i;
         bus.host_rdata_o[head]  = bus.dev_rdata_i;
      end
   end

   always_comb begin
      wrPtr_d    = handshake ? nextPtr(wrPtr_q) : wrPtr_q;
      rdPtr_d    = pop ? nextPtr(rdPtr_q) : rdPtr_q;
      count_d    = count_q;
      protoErr_d = protoErr_q;
      if (handshake && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!handshake && pop) begin
         count_d = count_q - CntW'(1);
      end
      if (bus.dev_rvalid_i && fifoEmpty) begin
         protoErr_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         protoErr_q <= 1'b0;
         for (int i = 0; i < MaxOutstanding; i++) begin
            owners_q[i] <= '0;
         end
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         protoErr_q <= protoErr_d;
         if (handshake) begin
            owners_q[wrPtr_q] <= winnerIdx;
         end
      end
   end

   logic unusedBe;
   assign unusedBe = ^BeWidth;
endmodule
